// File: rtl/result_aggregator_if.sv
// Tile-in / row-out bundle for result_aggregator.
// master = aggregator side, slave = surrounding fabric.
interface result_aggregator_if #(
    parameter int WIDTH       = 32,
    parameter int MATRIX_SIZE = 4,
    parameter int CHUNK_SIZE  = 2
);
    localparam int NUM_UNITS = (MATRIX_SIZE / CHUNK_SIZE) ** 2;
    localparam int CE        = CHUNK_SIZE * CHUNK_SIZE;
    localparam int IDXW      = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

    logic [NUM_UNITS-1:0]                  unit_valid;
    logic [NUM_UNITS-1:0][CE-1:0][WIDTH-1:0] unit_result;
    logic                                  in_ready;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [MATRIX_SIZE-1:0][WIDTH-1:0]     out_row;
    logic [IDXW-1:0]                       out_row_idx;
    logic                                  out_last;

    modport master (
        input  unit_valid,
        input  unit_result,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_row,
        output out_row_idx,
        output out_last
    );

    modport slave (
        output unit_valid,
        output unit_result,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_row,
        input  out_row_idx,
        input  out_last
    );
endinterface

// File: rtl/result_aggregator.sv
// Collects PIM tiles into a full matrix and streams it out row by row.
// Optional perf counters: define RESULT_AGGREGATOR_PERF_EN.
module result_aggregator #(
    parameter int WIDTH       = 32,
    parameter int MATRIX_SIZE = 4,
    parameter int CHUNK_SIZE  = 2,
    localparam int NUM_UNITS  = (MATRIX_SIZE / CHUNK_SIZE) ** 2
) (
    input  logic clk,
    input  logic rst,
    result_aggregator_if.master bus,
    input  logic err_clr,
    output logic dup_err,
    output logic ovf_err
`ifdef RESULT_AGGREGATOR_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [15:0] mat_cnt
`endif
);
    localparam int NB   = MATRIX_SIZE / CHUNK_SIZE;
    localparam int CE   = CHUNK_SIZE * CHUNK_SIZE;
    localparam int IDXW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int UW   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int EW   = (CE > 1) ? $clog2(CE) : 1;
    localparam logic [IDXW-1:0] LAST_ROW = IDXW'(MATRIX_SIZE - 1);

    if (MATRIX_SIZE % CHUNK_SIZE != 0) begin : g_bad_cfg
        $error("MATRIX_SIZE must be a multiple of CHUNK_SIZE");
    end

    typedef enum logic {
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_UNITS-1:0]   r_mask;
    logic [NUM_UNITS-1:0]   w_mask_nxt;
    logic [IDXW-1:0]        r_row_cnt;
    logic [IDXW-1:0]        w_row_nxt;
    logic [NUM_UNITS-1:0]   w_wr;
    logic                   w_dup;
    logic                   w_ovf;
    logic                   w_beat;
    logic                   w_last;
    logic                   r_dup_err;
    logic                   r_ovf_err;

    logic [MATRIX_SIZE-1:0][WIDTH-1:0] r_buf [MATRIX_SIZE];

    assign w_last = (r_state == S_DRAIN) && (r_row_cnt == LAST_ROW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_COLLECT;
            r_mask    <= '0;
            r_row_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mask    <= w_mask_nxt;
            r_row_cnt <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mask_nxt    = r_mask;
        w_row_nxt     = r_row_cnt;
        w_wr          = '0;
        w_dup         = 1'b0;
        w_ovf         = 1'b0;
        w_beat        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (r_state)
            S_COLLECT: begin
                bus.in_ready = 1'b1;
                w_wr         = bus.unit_valid & ~r_mask;
                w_dup        = |(bus.unit_valid & r_mask);
                w_mask_nxt   = r_mask | bus.unit_valid;
                if (&w_mask_nxt) begin
                    w_state_nxt = S_DRAIN;
                    w_row_nxt   = '0;
                end
            end
            S_DRAIN: begin
                bus.out_valid = 1'b1;
                w_ovf         = |bus.unit_valid;
                w_beat        = bus.out_ready;
                if (w_beat) begin
                    w_row_nxt = r_row_cnt + 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_COLLECT;
                        w_mask_nxt  = '0;
                        w_row_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    // Matrix storage carries no reset: out_row is ignored until refilled.
    always_ff @(posedge clk) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (w_wr[UW'(u)]) begin
                for (int i = 0; i < CHUNK_SIZE; i++) begin
                    for (int j = 0; j < CHUNK_SIZE; j++) begin
                        r_buf[IDXW'((u / NB) * CHUNK_SIZE + i)]
                             [IDXW'((u % NB) * CHUNK_SIZE + j)]
                            <= bus.unit_result[UW'(u)]
                                              [EW'(i * CHUNK_SIZE + j)];
                    end
                end
            end
        end
    end

    // A new error in the clear cycle keeps its flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dup_err <= 1'b0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_dup) begin
                r_dup_err <= 1'b1;
            end else if (err_clr) begin
                r_dup_err <= 1'b0;
            end
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end else if (err_clr) begin
                r_ovf_err <= 1'b0;
            end
        end
    end

    assign dup_err         = r_dup_err;
    assign ovf_err         = r_ovf_err;
    assign bus.out_row     = r_buf[r_row_cnt];
    assign bus.out_row_idx = r_row_cnt;
    assign bus.out_last    = w_last;

`ifdef RESULT_AGGREGATOR_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_mat_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_mat_cnt   <= '0;
        end else if (err_clr) begin
            r_stall_cnt <= '0;
            r_mat_cnt   <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_beat && w_last) begin
                r_mat_cnt <= r_mat_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign mat_cnt   = r_mat_cnt;
`endif
endmodule

// File: doc/result_aggregator.md
Name: result_aggregator

Overview:
- Sits directly downstream of the array of PIM compute units.
- Each unit emits one CHUNK_SIZE x CHUNK_SIZE result tile, flattened row-major, with a one-cycle valid pulse. This block captures every tile into a full MATRIX_SIZE x MATRIX_SIZE buffer.
- Once all tiles have arrived, it streams the product matrix out one row per beat over a valid/ready handshake.
- It flags protocol violations: duplicate tiles, and tiles arriving while draining.

Parameters:
- WIDTH, 32, element bit width; no widening, no truncation.
- MATRIX_SIZE, 4, full matrix dimension.
- CHUNK_SIZE, 2, tile dimension. MATRIX_SIZE must be a multiple of CHUNK_SIZE.
- NUM_UNITS, (MATRIX_SIZE/CHUNK_SIZE)**2, number of upstream units. Derived; do not override.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset: asserted when 0, released synchronously by the integrator.
- unit_valid  input  [NUM_UNITS-1:0]  per-unit tile-valid pulse.
- unit_result  input  [WIDTH-1:0] x [NUM_UNITS-1:0][CHUNK_SIZE**2-1:0]  per-unit tile, element index i*CHUNK_SIZE+j.
- in_ready  output  1  high while collecting; informational only, because upstream has no backpressure.
- out_valid  output  1  output row valid.
- out_ready  input  1  downstream accepts row.
- out_row  output  [WIDTH-1:0] x [MATRIX_SIZE-1:0]  current row, column 0 at index 0.
- out_row_idx  output  $clog2(MATRIX_SIZE)  index of the row presented.
- out_last  output  1  high with the final row (MATRIX_SIZE-1).
- dup_err  output  1  sticky: a tile was received twice in one collection.
- ovf_err  output  1  sticky: a tile arrived during DRAIN.
- err_clr  input  1  synchronous clear of both sticky errors.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=COLLECT, rcv_mask=0, row_cnt=0.
  - Outputs: out_valid=0, out_last=0, out_row_idx=0, in_ready=1, dup_err=0, ovf_err=0.
  - Buffer contents are not reset; out_row is don't-care while out_valid=0.
  - Reset mid-drain abandons the matrix; no further beats are produced.
- Tile mapping: unit u covers tile row br=u/(MATRIX_SIZE/CHUNK_SIZE) and tile column bc=u%(MATRIX_SIZE/CHUNK_SIZE). Element k=i*CHUNK_SIZE+j is written to buffer[br*CHUNK_SIZE+i][bc*CHUNK_SIZE+j].
- State COLLECT:
  - Every unit with unit_valid[u]=1 and rcv_mask[u]=0 has its tile written on this edge, and rcv_mask[u] is set.
  - Any number of units may be valid in the same cycle; all are captured.
  - unit_valid[u]=1 with rcv_mask[u]=1: the tile is ignored (first tile wins) and dup_err is set.
  - If (rcv_mask | unit_valid) == all ones at an edge, the next state is DRAIN, with row_cnt=0. Latency: last tile at edge T gives out_valid=1 in the cycle after T.
- State DRAIN:
  - out_valid=1, out_row=buffer[row_cnt], out_row_idx=row_cnt, out_last=(row_cnt==MATRIX_SIZE-1), in_ready=0.
  - out_row stays stable while out_valid=1 and out_ready=0.
  - Beat on out_valid&out_ready: row_cnt increments. If the beat carries out_last, the next state is COLLECT with rcv_mask=0 and row_cnt=0.
  - Any unit_valid in DRAIN, including the final-beat cycle: the tile is dropped, ovf_err is set, and the buffer is unchanged.
- Errors: dup_err and ovf_err clear only on reset or err_clr=1. If err_clr and a new error occur in the same cycle, the error wins (the flag stays set).
- No arithmetic is performed; values pass through bit-exact.

Optional Feature:
- Macro: RESULT_AGGREGATOR_PERF_EN.
- When defined, two extra output ports are added:
  - stall_cnt [31:0]: increments each cycle with out_valid=1 and out_ready=0; saturates at 32'hFFFF_FFFF.
  - mat_cnt [15:0]: increments on each out_last beat; wraps at 16 bits.
  - Both reset to 0 and are cleared by err_clr.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Tile arrival and stream-out:
  - Stimulus: units 0,1,2,3 pulse on separate cycles with tiles {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}; out_ready=1.
  - Required: rows [1,2,5,6], [3,4,7,8], [9,10,13,14], [11,12,15,16] on 4 consecutive beats; out_last only on row 3; out_valid rises in the cycle after unit 3 pulses.
- Same-cycle capture: all 4 units pulse in one cycle → identical output; DRAIN is entered in the next cycle.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during row 1.
  - Required: out_row stays [3,4,7,8] and out_row_idx stays 1 throughout; stall_cnt=5 with RESULT_AGGREGATOR_PERF_EN defined.
- Duplicate tile:
  - Stimulus: unit 2 pulses with tile {9,…} and later with {99,…} before collection completes.
  - Required: dup_err=1; row 2 starts [9,10,…]; err_clr=1 returns dup_err to 0.
- Overflow during drain: unit 0 pulses during row 2 → ovf_err=1; the remaining rows are unchanged; the next collection starts with an empty rcv_mask.
- Reset mid-drain: rst=0 during row 1 → out_valid=0 immediately (asynchronously); after release, state is COLLECT and in_ready=1, and a fresh 4-tile sequence streams correctly.
